sha256_msg_padder: RTL and testbench
====================================

SHA256_MSG_PADDER -- requirements
Module: sha256_msg_padder

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse; aborts any message and opens a new one.
- data_in  input  8  message byte.
- data_valid  input  1  data_in valid.
- data_last  input  1  qualifies data_in as final message byte.
- data_ready  output  1  byte accepted when data_valid && data_ready.
- word_out  output  32  big-endian message-schedule word.
- word_valid  output  1  word_out valid; held until accepted.
- word_ready  input  1  word accepted when word_valid && word_ready.
- word_idx  output  4  index of word_out within its 512-bit block.
- block_last  output  1  word_out is word 15 of a block.
- msg_last  output  1  word_out is final word of the padded message.
- msg_done  output  1  one-cycle pulse after final word accepted.
- err  output  1  sticky dropped-byte flag (see Configuration).

Function
REQ-002 SHALL implement states IDLE, ABSORB, PAD, LEN_HI, LEN_LO: IDLE->ABSORB on start; ABSORB->PAD on accepted byte with data_last; PAD->LEN_HI when next word to emit has word_idx 14; LEN_HI->LEN_LO->IDLE on word acceptance.
REQ-003 start SHALL take priority in every state: clear lane, word index, byte count, word_valid; enter ABSORB next cycle.
REQ-004 data_ready SHALL equal (state==ABSORB) && !word_valid.
REQ-005 Accepted bytes SHALL pack MSB-first into a 32-bit assembly word via a 2-bit lane counter; on the fourth byte the word SHALL load into word_out with word_valid high the next cycle.
REQ-006 A 61-bit byte counter SHALL increment per accepted byte, wrapping modulo 2^61; message bit length = count<<3 (64 bits).
REQ-007 After the last byte: if the current word is partial, remaining lanes SHALL be filled 0x80 then 0x00 and emitted; if complete, the next word SHALL be 0x80000000.
REQ-008 PAD SHALL emit 0x00000000 words until the next word_idx is 14; if the 0x80 word took index 14 or 15, zero words SHALL complete that block and fill indices 0-13 of a new block.
REQ-009 LEN_HI SHALL emit bit length [63:32] at word_idx 14; LEN_LO bits [31:0] at word_idx 15 with msg_last=1.
REQ-010 word_idx SHALL increment modulo 16 on each accepted word; block_last = (word_idx==15).
REQ-011 word_out, word_idx, block_last, msg_last SHALL be stable while word_valid && !word_ready.
REQ-012 msg_done SHALL pulse one cycle after the LEN_LO word is accepted.
REQ-013 Every message SHALL be at least one byte; zero-length messages are unsupported.

Reset
REQ-014 On rst: state IDLE; data_ready, word_valid, msg_done, err, block_last, msg_last = 0; word_out = 0; word_idx, lane, byte count = 0.
REQ-015 rst mid-message SHALL discard all partial data; no word emitted until a new start.

Configuration
REQ-016 With SHA256_PAD_ERR_EN defined: err SHALL set when data_valid is high while state != ABSORB, held until start or rst; byte discarded.
REQ-017 Without SHA256_PAD_ERR_EN: err SHALL be constant 0, no detection logic; byte discard unchanged.

Verification
REQ-018 start, 0x61,0x62,0x63(last), word_ready=1 -> 16 words: 0x61626380, 13x 0x00000000, 0x00000000, 0x00000018; block_last+msg_last on word 15; msg_done pulse.
REQ-019 55 bytes 0x00 -> one block; word 13 = 0x00000080; word 15 = 0x000001B8.
REQ-020 56 bytes -> 32 words; block1 word 14 = 0x80000000, word 15 = 0; block2 words 0-13 zero; final word 0x000001C0.
REQ-021 word_ready low 5 cycles mid-stream -> word_out/word_idx unchanged, data_ready low; resume with no loss or duplicate.
REQ-022 6 bytes then start -> word_valid drops next cycle; subsequent "abc" output identical to REQ-018.
REQ-023 SHA256_PAD_ERR_EN defined, data_valid in IDLE -> err=1 until start; undefined -> err stays 0.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: packs a byte stream into SHA-256 padded 32-bit message-schedule words.
// Ports: clk/rst (async, active-high); start opens a new message;
//   data_in/data_valid/data_last/data_ready form the byte stream in;
//   word_out/word_valid/word_ready form the word stream out, tagged with
//   word_idx (0-15 in block), block_last, msg_last; msg_done pulses after the
//   final word is taken; err is the sticky dropped-byte flag.
// Build option: define SHA256_PAD_ERR_EN to enable err detection (else err=0).
module sha256_msg_padder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        data_last,
  output logic        data_ready,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [3:0]  word_idx,
  output logic        block_last,
  output logic        msg_last,
  output logic        msg_done,
  output logic        err
);
  localparam logic [2:0] IDLE = 3'd0, ABSORB = 3'd1, PAD = 3'd2, LEN_HI = 3'd3, LEN_LO = 3'd4;
  logic [2:0]  state;
  logic [31:0] acc, acc_n, padded;
  logic [1:0]  lane;
  logic [60:0] cnt;
  logic        pend80, take, acc_w;
  logic [5:0]  sh;
  logic [63:0] bit_len;
  assign data_ready = (state == ABSORB) && !word_valid;
  assign take       = data_valid && data_ready;
  assign acc_w      = word_valid && word_ready;
  assign block_last = word_idx == 4'd15;
  assign bit_len    = {cnt, 3'b000};
  // acc_n drops the new byte into its lane; padded keeps the filled lanes and
  // appends 0x80 then zeros. A full word (sh==32) leaves padded==acc_n, so the
  // 0x80 marker has to follow as a separate word (pend80).
  always_comb begin
    acc_n  = (acc & ~(32'hFF00_0000 >> {lane, 3'b000})) | ({data_in, 24'h0} >> {lane, 3'b000});
    sh     = {1'b0, lane, 3'b000} + 6'd8;
    padded = (acc_n & ~(32'hFFFF_FFFF >> sh)) | (32'h8000_0000 >> sh);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      lane       <= '0;
      cnt        <= '0;
      pend80     <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      word_idx   <= '0;
      msg_last   <= 1'b0;
      msg_done   <= 1'b0;
    end else begin
      msg_done <= 1'b0;
      if (start) begin
        state      <= ABSORB;
        lane       <= '0;
        cnt        <= '0;
        pend80     <= 1'b0;
        word_valid <= 1'b0;
        word_idx   <= '0;
        msg_last   <= 1'b0;
      end else begin
        // word_idx always names the word being offered, or the next one to load
        if (acc_w) begin
          word_valid <= 1'b0;
          word_idx   <= word_idx + 4'd1;
        end
        case (state)
          ABSORB: if (take) begin
            acc  <= acc_n;
            lane <= lane + 2'd1;
            cnt  <= cnt + 61'd1;
            if (data_last) begin
              word_out   <= padded;
              word_valid <= 1'b1;
              pend80     <= lane == 2'd3;
              state      <= PAD;
            end else if (lane == 2'd3) begin
              word_out   <= acc_n;
              word_valid <= 1'b1;
            end
          end
          PAD: if (!word_valid) begin
            word_valid <= 1'b1;
            pend80     <= 1'b0;
            word_out   <= pend80 ? 32'h8000_0000 : (word_idx == 4'd14) ? bit_len[63:32] : 32'h0;
            if (!pend80 && word_idx == 4'd14) state <= LEN_HI;
          end
          // the low length word follows in the same cycle the high one is taken
          LEN_HI: if (acc_w) begin
            word_out   <= bit_len[31:0];
            word_valid <= 1'b1;
            msg_last   <= 1'b1;
            state      <= LEN_LO;
          end
          LEN_LO: if (acc_w) begin
            msg_last <= 1'b0;
            msg_done <= 1'b1;
            state    <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end
`ifdef SHA256_PAD_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (start) err <= 1'b0;
    else if (data_valid && state != ABSORB) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: directed bench for sha256_msg_padder with a byte-level padding model.
module tb_sha256_msg_padder;
  logic        clk = 1'b0, rst, start, data_valid, data_last, word_ready;
  logic [7:0]  data_in;
  logic        data_ready, word_valid, block_last, msg_last, msg_done, err;
  logic [31:0] word_out;
  logic [3:0]  word_idx;
  int total = 0, bad = 0;
  logic [7:0]  mbytes[$];
  logic [31:0] exp_q[$];
  logic [31:0] got[$];
  logic        pend_done = 1'b0;
  sha256_msg_padder dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .data_valid(data_valid),
    .data_last(data_last), .data_ready(data_ready), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .word_idx(word_idx),
    .block_last(block_last), .msg_last(msg_last), .msg_done(msg_done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask
  function automatic logic [7:0] gen(input int kind, input int i);
    return kind == 0 ? 8'(8'h61 + i) : kind == 1 ? 8'h00 : 8'(i * 37 + 5);
  endfunction
  // Standard SHA-256 padding on bytes: append 0x80, zero-fill to 56 mod 64, then 64-bit BE bit length.
  function automatic void build_exp();
    logic [7:0]  p[$];
    logic [63:0] bl;
    p = mbytes;
    bl = 64'(p.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[i*8 +: 8]);
    exp_q.delete();
    for (int i = 0; i < p.size(); i += 4) exp_q.push_back({p[i], p[i+1], p[i+2], p[i+3]});
  endfunction
  task automatic load(input int n, input int kind);
    mbytes.delete();
    for (int i = 0; i < n; i++) mbytes.push_back(gen(kind, i));
    build_exp();
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start();
    mbytes.delete();
    exp_q.delete();
    got.delete();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input logic last, input bit rnd);
    int t = 0;
    data_in = b;
    data_last = last;
    data_valid = 1'b1;
    while (!data_ready && t < 200) begin
      if (rnd) word_ready = 1'($urandom_range(0, 1));
      step();
      t++;
    end
    if (!data_ready) fail("data_ready timeout");
    else step();
    data_valid = 1'b0;
    data_last = 1'b0;
  endtask
  task automatic wait_done(input bit rnd);
    int t = 0;
    while (!msg_done && t < 3000) begin
      if (rnd) word_ready = 1'($urandom_range(0, 1));
      step();
      t++;
    end
    if (!msg_done) fail("msg_done timeout");
    word_ready = 1'b1;
    chk("words left", 64'(exp_q.size()), 64'd0);
  endtask
  task automatic send_msg(input int n, input int kind, input bit rnd);
    load(n, kind);
    for (int i = 0; i < n; i++) send(mbytes[i], i == n - 1, rnd);
    wait_done(rnd);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; data_valid = 1'b0; data_last = 1'b0; data_in = 8'h00; word_ready = 1'b1;
    fork
      forever begin
        int k;
        @(negedge clk);
        if (rst) pend_done = 1'b0;
        else begin
          chk("msg_done", 64'(msg_done), 64'(pend_done));
          pend_done = 1'b0;
          if (word_valid && word_ready) begin
            if (exp_q.size() == 0) fail("unexpected word");
            else begin
              k = got.size();
              chk("word", 64'(word_out), 64'(exp_q[0]));
              chk("word_idx", 64'(word_idx), 64'(k % 16));
              chk("block_last", 64'(block_last), 64'(k % 16 == 15));
              chk("msg_last", 64'(msg_last), 64'(exp_q.size() == 1));
              pend_done = exp_q.size() == 1;
              got.push_back(word_out);
              void'(exp_q.pop_front());
            end
          end
        end
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst data_ready", 64'(data_ready), 64'd0);
    chk("rst word_valid", 64'(word_valid), 64'd0);
    chk("rst msg_done", 64'(msg_done), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst block_last", 64'(block_last), 64'd0);
    chk("rst msg_last", 64'(msg_last), 64'd0);
    chk("rst word_out", 64'(word_out), 64'd0);
    chk("rst word_idx", 64'(word_idx), 64'd0);
    rst = 1'b0;
    step();
    load(3, 0);
    chk("model abc size", 64'(exp_q.size()), 64'd16);
    chk("model abc w0", 64'(exp_q[0]), 64'h61626380);
    chk("model abc w15", 64'(exp_q[15]), 64'h18);
    load(55, 1);
    chk("model 55 w13", 64'(exp_q[13]), 64'h80);
    chk("model 55 w15", 64'(exp_q[15]), 64'h1B8);
    load(56, 1);
    chk("model 56 size", 64'(exp_q.size()), 64'd32);
    chk("model 56 w14", 64'(exp_q[14]), 64'h80000000);
    chk("model 56 w31", 64'(exp_q[31]), 64'h1C0);
    exp_q.delete();
    do_start();
    send_msg(3, 0, 1'b0);
    chk("abc size", 64'(got.size()), 64'd16);
    chk("abc w0", 64'(got[0]), 64'h61626380);
    chk("abc w14", 64'(got[14]), 64'h0);
    chk("abc w15", 64'(got[15]), 64'h18);
    do_start();
    send_msg(55, 1, 1'b0);
    chk("55 size", 64'(got.size()), 64'd16);
    chk("55 w13", 64'(got[13]), 64'h80);
    chk("55 w15", 64'(got[15]), 64'h1B8);
    do_start();
    send_msg(56, 1, 1'b0);
    chk("56 size", 64'(got.size()), 64'd32);
    chk("56 w14", 64'(got[14]), 64'h80000000);
    chk("56 w15", 64'(got[15]), 64'h0);
    chk("56 w29", 64'(got[29]), 64'h0);
    chk("56 w31", 64'(got[31]), 64'h1C0);
    do_start();
    load(20, 2);
    word_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(mbytes[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall word", 64'(word_out), {32'h0, gen(2, 0), gen(2, 1), gen(2, 2), gen(2, 3)});
      chk("stall idx", 64'(word_idx), 64'd0);
      chk("stall valid", 64'(word_valid), 64'd1);
      chk("stall data_ready", 64'(data_ready), 64'd0);
    end
    word_ready = 1'b1;
    for (int i = 4; i < 20; i++) send(mbytes[i], i == 19, 1'b0);
    wait_done(1'b0);
    do_start();
    send_msg(61, 2, 1'b1);
    do_start();
    send_msg(100, 2, 1'b1);
    do_start();
    load(8, 2);
    for (int i = 0; i < 6; i++) send(mbytes[i], 1'b0, 1'b0);
    word_ready = 1'b0;
    send(mbytes[6], 1'b0, 1'b0);
    send(mbytes[7], 1'b0, 1'b0);
    chk("abort pre valid", 64'(word_valid), 64'd1);
    do_start();
    chk("abort valid", 64'(word_valid), 64'd0);
    chk("abort data_ready", 64'(data_ready), 64'd1);
    word_ready = 1'b1;
    send_msg(3, 0, 1'b0);
    chk("abort abc size", 64'(got.size()), 64'd16);
    chk("abort abc w0", 64'(got[0]), 64'h61626380);
    chk("abort abc w15", 64'(got[15]), 64'h18);
    do_start();
    for (int i = 0; i < 3; i++) send(gen(2, i), 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post rst valid", 64'(word_valid), 64'd0);
      chk("post rst data_ready", 64'(data_ready), 64'd0);
    end
    do_start();
    send_msg(3, 0, 1'b0);
    chk("rst abc w0", 64'(got[0]), 64'h61626380);
    chk("rst abc w15", 64'(got[15]), 64'h18);
    step();
    data_valid = 1'b1;
    step();
    step();
    data_valid = 1'b0;
`ifdef SHA256_PAD_ERR_EN
    chk("err idle", 64'(err), 64'd1);
    step();
    chk("err held", 64'(err), 64'd1);
`else
    chk("err idle", 64'(err), 64'd0);
`endif
    do_start();
    chk("err cleared", 64'(err), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
